// File: rtl/axi_wr_outst_fsm.sv
// Master-side AXI write FSM (AW/W/B) with up to MAX_OUTST bursts in flight.
// Optional protocol checks enabled by defining AXI_WR_PROTO_CHECK_EN.
module axi_wr_outst_fsm #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int MAX_OUTST = 4,
    parameter int CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic            axi_aclk,
    input  logic            rst,
    input  logic            awvalid_in,
    output logic            awready_out,
    input  logic [AW-1:0]   awaddr_in,
    input  logic [7:0]      awlen_in,
    input  logic [2:0]      awsize_in,
    input  logic [1:0]      awburst_in,
    output logic            axi_awvalid,
    output logic [AW-1:0]   axi_awaddr,
    output logic [7:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic [1:0]      axi_awburst,
    input  logic            axi_awready,
    input  logic            wvalid_in,
    input  logic [DW-1:0]   wdata_in,
    input  logic [DW/8-1:0] wstrb_in,
    output logic            wready_out,
    output logic            axi_wvalid,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wlast,
    input  logic            axi_wready,
    input  logic            axi_bvalid,
    input  logic [1:0]      axi_bresp,
    output logic            axi_bready,
    output logic            bvalid_out,
    output logic [1:0]      bresp_out,
    input  logic            bready_in,
    output logic [CW-1:0]   outst_cnt,
    output logic [2:0]      proto_err
);

    localparam int PW = $clog2(MAX_OUTST) + 1;
    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_BURST = 1'b1;

    logic            axi_awvalid_q, axi_awvalid_d;
    logic [AW-1:0]   axi_awaddr_q, axi_awaddr_d;
    logic [7:0]      axi_awlen_q, axi_awlen_d;
    logic [2:0]      axi_awsize_q, axi_awsize_d;
    logic [1:0]      axi_awburst_q, axi_awburst_d;
    logic            axi_wvalid_q, axi_wvalid_d;
    logic [DW-1:0]   axi_wdata_q, axi_wdata_d;
    logic [DW/8-1:0] axi_wstrb_q, axi_wstrb_d;
    logic            axi_wlast_q, axi_wlast_d;
    logic            bvalid_out_q, bvalid_out_d;
    logic [1:0]      bresp_out_q, bresp_out_d;
    logic [CW-1:0]   outst_cnt_q, outst_cnt_d;
    logic [0:0]      w_state_q, w_state_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      len_mem_q [MAX_OUTST];
    logic [7:0]      len_mem_d [MAX_OUTST];

    logic aw_acc, w_acc, b_hs, cnt_dec, fifo_empty;
    logic [7:0] fifo_head;

    assign awready_out = (outst_cnt_q < CW'(MAX_OUTST))
                      && (!axi_awvalid_q || axi_awready);
    assign wready_out  = (w_state_q == W_BURST)
                      && (!axi_wvalid_q || axi_wready);
    assign axi_bready  = !bvalid_out_q || bready_in;

    assign aw_acc     = awvalid_in && awready_out;
    assign w_acc      = wvalid_in && wready_out;
    assign b_hs       = axi_bvalid && axi_bready;
    assign cnt_dec    = b_hs && (outst_cnt_q != '0);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = len_mem_q[rd_ptr_q[PW-2:0]];

    always_comb begin
        axi_awvalid_d = axi_awvalid_q;
        axi_awaddr_d  = axi_awaddr_q;
        axi_awlen_d   = axi_awlen_q;
        axi_awsize_d  = axi_awsize_q;
        axi_awburst_d = axi_awburst_q;
        wr_ptr_d      = wr_ptr_q;
        len_mem_d     = len_mem_q;
        if (aw_acc) begin
            axi_awvalid_d = 1'b1;
            axi_awaddr_d  = awaddr_in;
            axi_awlen_d   = awlen_in;
            axi_awsize_d  = awsize_in;
            axi_awburst_d = awburst_in;
            len_mem_d[wr_ptr_q[PW-2:0]] = awlen_in;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (axi_awready) begin
            axi_awvalid_d = 1'b0;
        end
    end

    // A push into an empty FIFO starts the burst without waiting for the write.
    always_comb begin
        w_state_d  = w_state_q;
        beat_cnt_d = beat_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_state_q == W_IDLE) begin
            if (!fifo_empty) begin
                w_state_d  = W_BURST;
                beat_cnt_d = fifo_head;
            end else if (aw_acc) begin
                w_state_d  = W_BURST;
                beat_cnt_d = awlen_in;
            end
        end else if (w_acc) begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            if (beat_cnt_q == 8'd0) begin
                w_state_d = W_IDLE;
                rd_ptr_d  = rd_ptr_q + PW'(1);
            end
        end
    end

    always_comb begin
        axi_wvalid_d = axi_wvalid_q;
        axi_wdata_d  = axi_wdata_q;
        axi_wstrb_d  = axi_wstrb_q;
        axi_wlast_d  = axi_wlast_q;
        if (w_acc) begin
            axi_wvalid_d = 1'b1;
            axi_wdata_d  = wdata_in;
            axi_wstrb_d  = wstrb_in;
            axi_wlast_d  = (beat_cnt_q == 8'd0);
        end else if (axi_wready) begin
            axi_wvalid_d = 1'b0;
            axi_wlast_d  = 1'b0;
        end
    end

    always_comb begin
        bvalid_out_d = bvalid_out_q;
        bresp_out_d  = bresp_out_q;
        outst_cnt_d  = outst_cnt_q;
        if (b_hs) begin
            bvalid_out_d = 1'b1;
            bresp_out_d  = axi_bresp;
        end else if (bready_in) begin
            bvalid_out_d = 1'b0;
        end
        if (aw_acc && !cnt_dec)
            outst_cnt_d = outst_cnt_q + CW'(1);
        else if (!aw_acc && cnt_dec)
            outst_cnt_d = outst_cnt_q - CW'(1);
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            axi_awvalid_q <= 1'b0;
            axi_awaddr_q  <= '0;
            axi_awlen_q   <= '0;
            axi_awsize_q  <= '0;
            axi_awburst_q <= '0;
            axi_wvalid_q  <= 1'b0;
            axi_wdata_q   <= '0;
            axi_wstrb_q   <= '0;
            axi_wlast_q   <= 1'b0;
            bvalid_out_q  <= 1'b0;
            bresp_out_q   <= '0;
            outst_cnt_q   <= '0;
            w_state_q     <= W_IDLE;
            beat_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < MAX_OUTST; i++) len_mem_q[i] <= '0;
        end else begin
            axi_awvalid_q <= axi_awvalid_d;
            axi_awaddr_q  <= axi_awaddr_d;
            axi_awlen_q   <= axi_awlen_d;
            axi_awsize_q  <= axi_awsize_d;
            axi_awburst_q <= axi_awburst_d;
            axi_wvalid_q  <= axi_wvalid_d;
            axi_wdata_q   <= axi_wdata_d;
            axi_wstrb_q   <= axi_wstrb_d;
            axi_wlast_q   <= axi_wlast_d;
            bvalid_out_q  <= bvalid_out_d;
            bresp_out_q   <= bresp_out_d;
            outst_cnt_q   <= outst_cnt_d;
            w_state_q     <= w_state_d;
            beat_cnt_q    <= beat_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            len_mem_q     <= len_mem_d;
        end
    end

    assign axi_awvalid = axi_awvalid_q;
    assign axi_awaddr  = axi_awaddr_q;
    assign axi_awlen   = axi_awlen_q;
    assign axi_awsize  = axi_awsize_q;
    assign axi_awburst = axi_awburst_q;
    assign axi_wvalid  = axi_wvalid_q;
    assign axi_wdata   = axi_wdata_q;
    assign axi_wstrb   = axi_wstrb_q;
    assign axi_wlast   = axi_wlast_q;
    assign bvalid_out  = bvalid_out_q;
    assign bresp_out   = bresp_out_q;
    assign outst_cnt   = outst_cnt_q;

`ifdef AXI_WR_PROTO_CHECK_EN
    // wdone counts bursts whose last beat the slave took but whose B is pending.
    logic [CW-1:0] wdone_q, wdone_d;
    logic [2:0]    proto_err_q, proto_err_d;
    logic          wdone_inc, wdone_dec;

    assign wdone_inc = axi_wvalid_q && axi_wready && axi_wlast_q;
    assign wdone_dec = b_hs && (wdone_q != '0);

    always_comb begin
        wdone_d = wdone_q;
        if (wdone_inc && !wdone_dec)
            wdone_d = wdone_q + CW'(1);
        else if (!wdone_inc && wdone_dec)
            wdone_d = wdone_q - CW'(1);
        proto_err_d = proto_err_q | {
            b_hs && (outst_cnt_q != '0) && (wdone_q == '0),
            b_hs && (axi_bresp != 2'b00),
            axi_bvalid && (outst_cnt_q == '0)
        };
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            wdone_q     <= '0;
            proto_err_q <= '0;
        end else begin
            wdone_q     <= wdone_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 3'b000;
`endif

endmodule
